// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM state type and address widths for the load/store unit.
package mem_access_pkg;

  localparam int MEM_AW_DEF = 5;
  localparam int BYTE_AW    = MEM_AW_DEF + 2;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  // Byte offset of the addressed lane; misaligned low bits are dropped.
  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_B:  lane_off = a;
      SIZE_H:  lane_off = {a[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane handling: sub-word store merge and load extract/extend (little-endian).
module lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] rdata
);

  logic [1:0]        off;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    off     = lane_off(size, addr_lo);
    shifted = word >> {off, 3'b000};
    merged  = word;
    rdata   = word;
    case (size)
      SIZE_B: begin
        merged[{off, 3'b000} +: 8] = wdata[7:0];
        rdata = {{(DATA_W-8){sext & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        merged[{off, 3'b000} +: 16] = wdata[15:0];
        rdata = {{(DATA_W-16){sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        merged = wdata;
        rdata  = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a single-port word memory; sub-word stores use read-modify-write.
// Optional macro MISALIGN_TRAP_EN: misaligned requests complete immediately with rsp_err.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [MEM_AW+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  state_t            state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [1:0]        addr_lo_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_data;
  logic              misalign;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    case (req_size)
      SIZE_B:  misalign = 1'b0;
      SIZE_H:  misalign = req_addr[0];
      default: misalign = |req_addr[1:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign mem_we    = (state == WR);

  lane_align #(.DATA_W(DATA_W)) u_lane (
    .size    (size_q),
    .sext    (sext_q),
    .addr_lo (addr_lo_q),
    .wdata   (wdata_q),
    .word    (mem_rd),
    .merged  (merged),
    .rdata   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      size_q    <= SIZE_B;
      sext_q    <= 1'b0;
      addr_lo_q <= 2'b00;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_a     <= '0;
      mem_wd    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we_q      <= req_we;
          size_q    <= req_size;
          sext_q    <= req_signed;
          addr_lo_q <= req_addr[1:0];
          wdata_q   <= req_wdata;
          mem_a     <= req_addr[MEM_AW+1:2];
          mem_wd    <= req_wdata;
          if (misalign) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else if (req_we && req_size[1]) begin
            state <= WR;
          end else begin
            state <= RD;
          end
        end
        RD: begin
          // Stores merge into the fetched word; loads finish straight from it.
          if (we_q) begin
            mem_wd <= merged;
            state  <= WR;
          end else begin
            rsp_rdata <= load_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WR: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
